// File: rtl/Bit16Reg.sv
// rtl/Bit16Reg.sv - 16-bit write-enabled register with asynchronous active-low clear
module Bit16Reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] d,
    output logic [15:0] q
);

    // Hold the value until en loads new data; rst clears immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 16'h0000;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file_16x16.sv
// rtl/reg_file_16x16.sv - 16x16 register file, two async read ports, one write port with bypass
module reg_file_16x16 #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter bit ZERO_R0  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        src_reg1,
    input  logic [3:0]        src_reg2,
    input  logic [3:0]        dst_reg,
    input  logic              write_reg,
    input  logic [DATA_W-1:0] dst_data,
    output logic [DATA_W-1:0] src_data1,
    output logic [DATA_W-1:0] src_data2,
    output logic              wr_ack
);

    logic                wr_discard;
    logic                wr_accept;
    logic [NUM_REGS-1:0] wr_en;
    logic [DATA_W-1:0]   entry_q [NUM_REGS];

    // A write to R0 is dropped when R0 is hardwired; a write during reset never lands
    assign wr_discard = ZERO_R0 && (dst_reg == 4'd0);
    assign wr_accept  = write_reg && rst && !wr_discard;

    // One-hot write enable: a single entry, or none when no write is accepted
    always_comb begin
        wr_en = '0;
        if (wr_accept) begin
            wr_en[dst_reg] = 1'b1;
        end
    end

    // R0 is still a physical register; with ZERO_R0 its enable is never raised
    // and the read path masks it, so it stays at its reset value
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
        Bit16Reg u_reg (
            .clk (clk),
            .rst (rst),
            .en  (wr_en[i]),
            .d   (dst_data),
            .q   (entry_q[i])
        );
    end

    // Read port 1: R0 forced to zero, then same-cycle bypass, then stored value
    always_comb begin
        src_data1 = entry_q[src_reg1];
        if (ZERO_R0 && (src_reg1 == 4'd0)) begin
            src_data1 = '0;
        end else if (wr_accept && (dst_reg == src_reg1)) begin
            src_data1 = dst_data;
        end
    end

    // Read port 2: same priority as port 1
    always_comb begin
        src_data2 = entry_q[src_reg2];
        if (ZERO_R0 && (src_reg2 == 4'd0)) begin
            src_data2 = '0;
        end else if (wr_accept && (dst_reg == src_reg2)) begin
            src_data2 = dst_data;
        end
    end

    // Acknowledge each accepted write one cycle later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ack <= 1'b0;
        end else begin
            wr_ack <= wr_accept;
        end
    end

endmodule

// File: doc/reg_file_16x16.md
Name: reg_file_16x16

Overview:
- 16-entry by 16-bit general-purpose register file for the 16-bit CPU datapath.
- Two asynchronous read ports serve decode; one synchronous write port is fed by write-back.
- Each entry is a write-enabled 16-bit register instance of Bit16Reg, with one-hot write decode.
- Includes write-to-read bypass so decode sees same-cycle write-back data, and a hardwired-zero R0.

Parameters:
- DATA_W, 16, register width; fixed at 16 to match Bit16Reg.
- NUM_REGS, 16, entry count; address width is log2(NUM_REGS) = 4.
- ZERO_R0, 1, when 1, entry 0 ignores writes and always reads 0x0000.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset; 0 clears all entries immediately
- src_reg1  input  4  read port 1 address
- src_reg2  input  4  read port 2 address
- dst_reg  input  4  write address
- write_reg  input  1  write enable
- dst_data  input  16  write data
- src_data1  output  16  read port 1 data
- src_data2  output  16  read port 2 data
- wr_ack  output  1  registered; 1 for one cycle after an accepted (non-discarded) write

Behaviour:
- Reset, rst=0, asynchronous, independent of clk:
  - All 16 entries go to 0x0000 and wr_ack goes to 0.
  - Read outputs therefore show 0x0000 for every address while rst is low.
- Reset release: first capturing edge is the first rising clk with rst=1. No write is lost or duplicated across release.
- Write, one write per cycle:
  - On rising clk with write_reg=1 and rst=1, entry[dst_reg] <= dst_data.
  - Write-enable decode is one-hot: exactly one entry's enable is asserted, or none when write_reg=0.
  - ZERO_R0=1 and dst_reg=0: the write is discarded, no entry changes, and wr_ack stays 0.
- wr_ack:
  - Equals 1 on the cycle after an accepted write, otherwise 0.
  - Back-to-back writes hold it high continuously.
- Read, combinational, zero latency: src_dataN = entry[src_regN].
- Bypass:
  - If write_reg=1 and dst_reg==src_regN (and not the R0-discard case), src_dataN = dst_data in the same cycle, before the edge.
  - Both ports may bypass simultaneously when src_reg1==src_reg2==dst_reg.
- R0 (ZERO_R0=1): src_regN=0 returns 0x0000 regardless of write_reg/dst_data. No bypass on R0.
- Simultaneous read/write of different addresses: reads return old stored values; the write lands at the edge.
- Reset asserted mid-write (rst falls while write_reg=1): reset wins; the entry ends at 0x0000 and the write is lost.
- No X propagation:
  - Undriven write_reg is not permitted.
  - All addresses 0-15 are valid, so there is no out-of-range case.

Test Plan:
- Reset and readback: pulse rst low mid-cycle, release, read all 16 addresses on both ports -> every read returns 0x0000 and wr_ack=0.
- Write then read: write R5=0xA5C3, next cycle src_reg1=5, src_reg2=5 -> both ports return 0xA5C3; wr_ack=1 for exactly one cycle.
- Same-cycle bypass on both ports: R7 holds 0x1111; set write_reg=1, dst_reg=7, dst_data=0xBEEF, src_reg1=7, src_reg2=7.
  - Before the edge, both ports return 0xBEEF.
  - After the edge, R7 reads 0xBEEF.
- R0 protection: write R0=0xFFFF, then read src_reg1=0, including the same-cycle bypass case -> 0x0000 both times; wr_ack stays 0.
- Walking writes: write Rn=0x1000+n for n=1..15 back-to-back -> wr_ack high for 15 consecutive cycles; each Rn reads 0x1000+n; R0 still 0x0000.
- Async reset mid-write: R3=0x1234, then write_reg=1, dst_reg=3, dst_data=0x5678; drop rst before the edge -> R3 reads 0x0000 after release and wr_ack=0.
